hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard sequencer for the 5-stage RISC-V core; sits beside forwarding_unit and drives the stall, bubble and flush controls of the PC, IF/ID, ID/EX and EX/MEM registers.
- Covers the hazards forwarding cannot hide: load-use into the ALU, load feeding an ID-stage branch compare, taken-branch redirect, and multi-cycle EX ops (mul/div) over a req/done handshake with a timeout.

Parameters:
- MC_TIMEOUT, 64, max cycles in MC_WAIT before abort (>=2).
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- IF_ID_rs1, IF_ID_rs2  in  5 each  source regs of the instruction in ID
- IF_ID_uses_rs2  in  1  ID instruction reads rs2
- branch  in  1  ID holds a conditional branch
- branch_taken  in  1  ID compare result, valid only when branch=1
- ID_EX_rd  in  5  destination in EX
- ID_EX_mem_read  in  1  EX holds a load
- ID_EX_mc_op  in  1  EX holds a multi-cycle op
- EX_MEM_rd  in  5  destination in MEM
- EX_MEM_mem_read  in  1  MEM holds a load
- mc_done  in  1  multi-cycle unit result ready (1-cycle pulse)
- pc_write  out  1  PC enable
- IF_ID_write  out  1  IF/ID enable
- IF_ID_flush  out  1  IF/ID loads NOP
- ID_EX_bubble  out  1  ID/EX loads NOP
- ID_EX_hold  out  1  ID/EX keeps contents
- EX_MEM_bubble  out  1  EX/MEM loads NOP
- mc_req  out  1  start pulse to multi-cycle unit
- mc_abort  out  1  timeout abort pulse
- mc_err  out  1  sticky timeout flag
- stall_cycles  out  CNT_W  perf counter
- flush_count  out  CNT_W  perf counter

Behaviour:
- Reset: state=RUN, timer=0, mc_err=0, counters=0. Outputs during rst: pc_write=1, IF_ID_write=1, all others 0.
- Control outputs are Mealy, valid in the same cycle; state and timer are registered.
- States: RUN, BR_LOAD2, MC_WAIT.
- RUN, evaluated in priority order:
  1. ID_EX_mc_op=1: mc_req=1, pc_write=0, IF_ID_write=0, ID_EX_hold=1, EX_MEM_bubble=1, timer<=0, next MC_WAIT.
  2. Branch-on-load: branch=1, ID_EX_mem_read=1, ID_EX_rd!=0, and ID_EX_rd equals rs1, or equals rs2 with IF_ID_uses_rs2=1. Then stall (pc_write=0, IF_ID_write=0, ID_EX_bubble=1), next BR_LOAD2.
  3. Load-use, same match with branch=0: stall for 1 cycle, stay RUN.
  4. Branch-on-MEM-load: branch=1, EX_MEM_mem_read=1, EX_MEM_rd!=0, match as above. Stall 1 cycle, stay RUN.
  5. Otherwise, if branch and branch_taken: IF_ID_flush=1 for 1 cycle, PC advances normally.
- branch_taken is ignored in any stall cycle.
- BR_LOAD2: unconditional second stall (same three outputs), next RUN. The compare then uses the MEM/WB value.
- MC_WAIT:
  - Hold outputs as in RUN item 1, with mc_req=0. timer increments each cycle.
  - mc_done=1: release all stalls this cycle, next RUN.
  - timer==MC_TIMEOUT-1 with no mc_done: mc_abort=1, mc_err<=1, EX_MEM_bubble=1, release, next RUN.
  - mc_done and timeout in the same cycle: mc_done wins, no abort.
- Register 0 never causes a hazard.
- rst in any state returns to RUN next cycle. No mc_req is reissued.
- mc_err clears only on rst.
- Counters saturate at all-ones; no wrap-around.

Optional Feature:
- HAZARD_PERF_CNT_EN defined:
  - stall_cycles increments on every cycle with pc_write=0.
  - flush_count increments on every IF_ID_flush=1.
- Undefined: both outputs tied to 0, no counter flops.

Decomposition:
- Package riscv_hazard_pkg: hz_state_e enum {RUN, BR_LOAD2, MC_WAIT}, REG_ZERO=5'd0, default MC_TIMEOUT constant.
- Sub-module hazard_perf_cnt: one saturating CNT_W counter with inc/clear, instantiated twice under the macro.

Test Plan:
- Load-use: ID_EX_mem_read=1, ID_EX_rd=5, IF_ID_rs1=5, branch=0 -> exactly 1 cycle of pc_write=0, IF_ID_write=0, ID_EX_bubble=1; next cycle no stall.
- Branch-on-load: branch=1, ID_EX_mem_read=1, ID_EX_rd=7, IF_ID_rs2=7, IF_ID_uses_rs2=1 -> 2 consecutive stall cycles, state RUN->BR_LOAD2->RUN; branch_taken=1 during stalls gives no flush.
- Taken branch, no hazard: branch=1, branch_taken=1 -> IF_ID_flush=1 one cycle, pc_write=1; flush_count +1 with macro.
- Multi-cycle: ID_EX_mc_op=1, mc_done after 10 cycles -> mc_req single pulse, stall for 11 cycles total, release on the mc_done cycle.
- Timeout: MC_TIMEOUT=8, no mc_done -> mc_abort pulse on 8th MC_WAIT cycle, mc_err=1 sticky; mc_done in that same cycle instead gives no abort.
- Reset mid MC_WAIT: rst at cycle 3 -> next cycle state RUN, all stalls released, mc_err=0, counters=0.

Source files
------------

// File: rtl/riscv_hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package riscv_hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        BR_LOAD2 = 2'd1,
        MC_WAIT  = 2'd2
    } hz_state_e;

    localparam logic [4:0] REG_ZERO       = 5'd0;
    localparam int         MC_TIMEOUT_DEF = 64;

    // x0 is hardwired to zero, so a write to it can never feed a reader.
    function automatic logic reg_hit(input logic [4:0] rd,
                                     input logic [4:0] rs1,
                                     input logic [4:0] rs2,
                                     input logic       uses_rs2);
        return (rd != REG_ZERO) && ((rd == rs1) || (uses_rs2 && (rd == rs2)));
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter used for the hazard performance statistics.
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use / branch-on-load stalls, branch flush and
// multi-cycle EX handshake with timeout. Perf counters built only with HAZARD_PERF_CNT_EN.
//
// state    | meaning
// RUN      | normal issue, hazards resolved in priority order
// BR_LOAD2 | second stall for a branch waiting on a load in EX
// MC_WAIT  | multi-cycle op in EX, waiting for mc_done or timeout
module hazard_ctrl
    import riscv_hazard_pkg::*;
#(
    parameter int MC_TIMEOUT = MC_TIMEOUT_DEF,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IF_ID_rs1,
    input  logic [4:0]       IF_ID_rs2,
    input  logic             IF_ID_uses_rs2,
    input  logic             branch,
    input  logic             branch_taken,
    input  logic [4:0]       ID_EX_rd,
    input  logic             ID_EX_mem_read,
    input  logic             ID_EX_mc_op,
    input  logic [4:0]       EX_MEM_rd,
    input  logic             EX_MEM_mem_read,
    input  logic             mc_done,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_bubble,
    output logic             ID_EX_hold,
    output logic             EX_MEM_bubble,
    output logic             mc_req,
    output logic             mc_abort,
    output logic             mc_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int              TMR_W    = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MC_TIMEOUT - 1);

    hz_state_e        state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             err_q, err_set;
    logic             ex_hit, mem_hit;

    assign ex_hit  = ID_EX_mem_read  && reg_hit(ID_EX_rd,  IF_ID_rs1, IF_ID_rs2, IF_ID_uses_rs2);
    assign mem_hit = EX_MEM_mem_read && reg_hit(EX_MEM_rd, IF_ID_rs1, IF_ID_rs2, IF_ID_uses_rs2);

    always_comb begin
        pc_write      = 1'b1;
        IF_ID_write   = 1'b1;
        IF_ID_flush   = 1'b0;
        ID_EX_bubble  = 1'b0;
        ID_EX_hold    = 1'b0;
        EX_MEM_bubble = 1'b0;
        mc_req        = 1'b0;
        mc_abort      = 1'b0;
        err_set       = 1'b0;
        state_d       = state_q;
        timer_d       = timer_q;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (ID_EX_mc_op) begin
                        mc_req        = 1'b1;
                        pc_write      = 1'b0;
                        IF_ID_write   = 1'b0;
                        ID_EX_hold    = 1'b1;
                        EX_MEM_bubble = 1'b1;
                        timer_d       = '0;
                        state_d       = MC_WAIT;
                    end else if (ex_hit || (branch && mem_hit)) begin
                        pc_write     = 1'b0;
                        IF_ID_write  = 1'b0;
                        ID_EX_bubble = 1'b1;
                        if (branch)
                            state_d = BR_LOAD2;
                    end else if (branch && branch_taken) begin
                        IF_ID_flush = 1'b1;
                    end
                end
                BR_LOAD2: begin
                    pc_write     = 1'b0;
                    IF_ID_write  = 1'b0;
                    ID_EX_bubble = 1'b1;
                    state_d      = RUN;
                end
                MC_WAIT: begin
                    if (mc_done) begin
                        state_d = RUN;
                    end else if (timer_q == TMR_LAST) begin
                        // Result will never arrive: squash what EX would pass on.
                        mc_abort      = 1'b1;
                        EX_MEM_bubble = 1'b1;
                        err_set       = 1'b1;
                        state_d       = RUN;
                    end else begin
                        pc_write      = 1'b0;
                        IF_ID_write   = 1'b0;
                        ID_EX_hold    = 1'b1;
                        EX_MEM_bubble = 1'b1;
                        timer_d       = timer_q + 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
            // A branch-on-MEM-load stall resolves in one cycle; only an EX load needs two.
            if ((state_q == RUN) && !ID_EX_mc_op && !ex_hit)
                state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            if (err_set)
                err_q <= 1'b1;
        end
    end

    assign mc_err = err_q & ~rst;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (~pc_write),
        .count (stall_q)
    );

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (IF_ID_flush),
        .count (flush_q)
    );

    assign stall_cycles = rst ? '0 : stall_q;
    assign flush_count  = rst ? '0 : flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (default timeout/width and timeout 8 with
// 4-bit counters) driven together and checked against a behavioural model.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] IF_ID_rs1, IF_ID_rs2, ID_EX_rd, EX_MEM_rd;
    logic       IF_ID_uses_rs2, branch, branch_taken, ID_EX_mem_read;
    logic       ID_EX_mc_op, EX_MEM_mem_read, mc_done;

    logic [1:0] pc_w, ifid_w, flush_o, bub_o, hold_o, exbub_o, req_o, abort_o, err_o;
    logic [31:0] st0, fl0;
    logic [3:0]  st1, fl1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rst(rst), .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
        .IF_ID_uses_rs2(IF_ID_uses_rs2), .branch(branch), .branch_taken(branch_taken),
        .ID_EX_rd(ID_EX_rd), .ID_EX_mem_read(ID_EX_mem_read), .ID_EX_mc_op(ID_EX_mc_op),
        .EX_MEM_rd(EX_MEM_rd), .EX_MEM_mem_read(EX_MEM_mem_read), .mc_done(mc_done),
        .pc_write(pc_w[0]), .IF_ID_write(ifid_w[0]), .IF_ID_flush(flush_o[0]),
        .ID_EX_bubble(bub_o[0]), .ID_EX_hold(hold_o[0]), .EX_MEM_bubble(exbub_o[0]),
        .mc_req(req_o[0]), .mc_abort(abort_o[0]), .mc_err(err_o[0]),
        .stall_cycles(st0), .flush_count(fl0)
    );

    hazard_ctrl #(.MC_TIMEOUT(8), .CNT_W(4)) dut8 (
        .clk(clk), .rst(rst), .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
        .IF_ID_uses_rs2(IF_ID_uses_rs2), .branch(branch), .branch_taken(branch_taken),
        .ID_EX_rd(ID_EX_rd), .ID_EX_mem_read(ID_EX_mem_read), .ID_EX_mc_op(ID_EX_mc_op),
        .EX_MEM_rd(EX_MEM_rd), .EX_MEM_mem_read(EX_MEM_mem_read), .mc_done(mc_done),
        .pc_write(pc_w[1]), .IF_ID_write(ifid_w[1]), .IF_ID_flush(flush_o[1]),
        .ID_EX_bubble(bub_o[1]), .ID_EX_hold(hold_o[1]), .EX_MEM_bubble(exbub_o[1]),
        .mc_req(req_o[1]), .mc_abort(abort_o[1]), .mc_err(err_o[1]),
        .stall_cycles(st1), .flush_count(fl1)
    );

    // Reference model: "owed" stalls and wait progress tracked as plain counts.
    typedef struct {
        bit     waiting;
        bit     pend2;
        bit     err;
        int     wait_n;
        longint stalls;
        longint flushes;
    } mdl_t;

    mdl_t   m [2];
    int     tmo  [2] = '{64, 8};
    longint cmax [2] = '{64'hFFFF_FFFF, 64'd15};

    function automatic bit uses(input logic [4:0] rd);
        return (rd != 5'd0) && ((rd == IF_ID_rs1) || (IF_ID_uses_rs2 && rd == IF_ID_rs2));
    endfunction

    // ctrl = {pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, ID_EX_hold,
    //         EX_MEM_bubble, mc_req, mc_abort, mc_err}
    task automatic step_model(input int k, output logic [8:0] ctrl,
                              output longint st, output longint fl);
        bit pc = 1, ifid = 1, fls = 0, bub = 0, hold = 0, exb = 0, req = 0, abt = 0;
        bit ex_ld  = ID_EX_mem_read  && uses(ID_EX_rd);
        bit mem_ld = EX_MEM_mem_read && uses(EX_MEM_rd);
        if (rst) begin
            ctrl = 9'b1_1000_0000;
            st = 0;
            fl = 0;
            m[k] = '{default: 0};
            return;
        end
        ctrl = '0;
        `ifdef HAZARD_PERF_CNT_EN
        st = m[k].stalls;
        fl = m[k].flushes;
        `else
        st = 0;
        fl = 0;
        `endif
        if (m[k].waiting) begin
            if (mc_done) begin
                m[k].waiting = 0;
            end else if (m[k].wait_n == tmo[k] - 1) begin
                abt = 1; exb = 1; m[k].waiting = 0;
            end else begin
                pc = 0; ifid = 0; hold = 1; exb = 1; m[k].wait_n++;
            end
        end else if (m[k].pend2) begin
            pc = 0; ifid = 0; bub = 1; m[k].pend2 = 0;
        end else if (ID_EX_mc_op) begin
            req = 1; pc = 0; ifid = 0; hold = 1; exb = 1;
            m[k].waiting = 1; m[k].wait_n = 0;
        end else if (branch && ex_ld) begin
            pc = 0; ifid = 0; bub = 1; m[k].pend2 = 1;
        end else if ((!branch && ex_ld) || (branch && mem_ld)) begin
            pc = 0; ifid = 0; bub = 1;
        end else if (branch && branch_taken) begin
            fls = 1;
        end
        ctrl = {pc, ifid, fls, bub, hold, exb, req, abt, m[k].err};
        if (abt) m[k].err = 1;
        if (!pc  && m[k].stalls  < cmax[k]) m[k].stalls++;
        if (fls  && m[k].flushes < cmax[k]) m[k].flushes++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cycle();
        logic [8:0] c;
        longint     s, f;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            step_model(k, c, s, f);
            chk(k == 0 ? "ctrl_t64" : "ctrl_t8",
                64'({pc_w[k], ifid_w[k], flush_o[k], bub_o[k], hold_o[k],
                     exbub_o[k], req_o[k], abort_o[k], err_o[k]}), 64'(c));
            chk(k == 0 ? "stall_cnt_t64" : "stall_cnt_t8",
                k == 0 ? 64'(st0) : 64'(st1), 64'(s));
            chk(k == 0 ? "flush_cnt_t64" : "flush_cnt_t8",
                k == 0 ? 64'(fl0) : 64'(fl1), 64'(f));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; IF_ID_rs1 = 0; IF_ID_rs2 = 0; IF_ID_uses_rs2 = 0; branch = 0;
        branch_taken = 0; ID_EX_rd = 0; ID_EX_mem_read = 0; ID_EX_mc_op = 0;
        EX_MEM_rd = 0; EX_MEM_mem_read = 0; mc_done = 0;
    endtask

    task automatic mc_start();
        ID_EX_mc_op = 1; cycle();
        ID_EX_mc_op = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        @(posedge clk); #1;
        cycle(); cycle();
        rst = 0;
        cycle();

        // load-use on rs1
        ID_EX_mem_read = 1; ID_EX_rd = 5; IF_ID_rs1 = 5; cycle();
        idle(); cycle();

        // x0 never hazards
        ID_EX_mem_read = 1; ID_EX_rd = 0; IF_ID_rs1 = 0; cycle();
        idle(); cycle();

        // branch-on-load via rs2, taken during both stalls, then resolves
        branch = 1; branch_taken = 1; ID_EX_mem_read = 1; ID_EX_rd = 7;
        IF_ID_rs2 = 7; IF_ID_uses_rs2 = 1; cycle();
        ID_EX_mem_read = 0; EX_MEM_mem_read = 1; EX_MEM_rd = 7; cycle();
        EX_MEM_mem_read = 0; cycle();
        idle(); cycle();

        // branch on a load already in MEM: one stall
        branch = 1; branch_taken = 1; EX_MEM_mem_read = 1; EX_MEM_rd = 3; IF_ID_rs1 = 3; cycle();
        EX_MEM_mem_read = 0; cycle();
        idle(); cycle();

        // plain taken branch
        branch = 1; branch_taken = 1; cycle();
        idle(); cycle();

        // multi-cycle op, done after 10 wait cycles
        mc_start();
        repeat (10) cycle();
        mc_done = 1; cycle();
        mc_done = 0; repeat (3) cycle();

        // timeout with no done
        mc_start();
        repeat (66) cycle();

        // done coincides with the 8-cycle timeout
        mc_start();
        repeat (7) cycle();
        mc_done = 1; cycle();
        mc_done = 0; repeat (2) cycle();

        // reset in the middle of a wait
        mc_start();
        repeat (3) cycle();
        rst = 1; cycle();
        rst = 0; repeat (3) cycle();

        // randomized traffic: frequent completions, then rare ones
        for (int phase = 0; phase < 2; phase++) begin
            for (int i = 0; i < 1500; i++) begin
                IF_ID_rs1       = 5'($urandom_range(0, 3));
                IF_ID_rs2       = 5'($urandom_range(0, 3));
                ID_EX_rd        = 5'($urandom_range(0, 3));
                EX_MEM_rd       = 5'($urandom_range(0, 3));
                IF_ID_uses_rs2  = 1'($urandom_range(0, 1));
                branch          = 1'($urandom_range(0, 1));
                branch_taken    = 1'($urandom_range(0, 1));
                ID_EX_mem_read  = ($urandom_range(0, 2) == 0);
                EX_MEM_mem_read = ($urandom_range(0, 2) == 0);
                ID_EX_mc_op     = ($urandom_range(0, 15) == 0);
                mc_done         = (phase == 0) ? ($urandom_range(0, 9) == 0)
                                               : ($urandom_range(0, 79) == 0);
                rst             = ($urandom_range(0, 299) == 0);
                cycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
